w_sched: RTL and testbench

SHA-256 message-schedule generator: accepts one 512-bit block as 16 serial 32-bit words and streams out W0..W63, one word per handshake. It sits between the block loader and the compression-round datapath. Internally it holds a 16-entry circular window and evaluates W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] for t ≥ 16.

---
 rtl/w_sched.sv | 156 +++++++++++++++
 tb/tb_w_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_sched.sv
`default_nettype none
// ============================================================================
// Module   : w_sched
// Purpose  : SHA-256 message-schedule generator. Loads 16 words, streams W0..W63.
//            Optional block counter port enabled by W_SCHED_BLKCNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module w_sched (
  input  logic        clock,
  input  logic        reset,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [31:0] blk_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_out,
  output logic [5:0]  w_idx,
  output logic        w_last,
  output logic        busy
`ifdef W_SCHED_BLKCNT_EN
  ,
  output logic [15:0] blk_count
`endif
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_ld_cnt;
  logic [5:0]  r_t;
  logic [31:0] r_win [16];

  logic        w_ld_fire;
  logic        w_out_load;
  logic        w_drain_done;
  logic [3:0]  w_t_lo;
  logic [31:0] w_sum;
  logic [31:0] w_word;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // The window slot for t still holds W[t-16] until the new sum overwrites it.
  assign w_t_lo = r_t[3:0];
  assign w_sum  = sig1(r_win[w_t_lo - 4'd2]) + r_win[w_t_lo - 4'd7]
                + sig0(r_win[w_t_lo - 4'd15]) + r_win[w_t_lo];
  assign w_word = (r_t[5:4] == 2'b00) ? r_win[w_t_lo] : w_sum;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ld_fire    = 1'b0;
    w_out_load   = 1'b0;
    w_drain_done = 1'b0;
    blk_ready    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_LOAD: begin
        blk_ready = reset;
        busy      = 1'b0;
        w_ld_fire = blk_valid;
        if (blk_valid && (r_ld_cnt == 4'd15)) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_out_load = !w_valid || w_ready;
        if (w_out_load && (r_t == 6'd63)) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_drain_done = w_valid && w_ready;
        if (w_drain_done) begin
          w_state_next = ST_LOAD;
        end
      end
      default: begin
        w_state_next = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ld_cnt <= 4'd0;
      r_t      <= 6'd0;
      w_valid  <= 1'b0;
      w_out    <= 32'd0;
      w_idx    <= 6'd0;
      w_last   <= 1'b0;
    end else begin
      if (w_ld_fire) begin
        r_ld_cnt <= r_ld_cnt + 4'd1;
        if (r_ld_cnt == 4'd15) begin
          r_t <= 6'd0;
        end
      end
      if (w_out_load) begin
        w_valid <= 1'b1;
        w_out   <= w_word;
        w_idx   <= r_t;
        w_last  <= (r_t == 6'd63);
        r_t     <= r_t + 6'd1;
      end
      if (w_drain_done) begin
        w_valid <= 1'b0;
        w_last  <= 1'b0;
      end
    end
  end

  // Window storage is deliberately left uncleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (w_ld_fire) begin
        r_win[r_ld_cnt] <= blk_word;
      end else if (w_out_load && (r_t[5:4] != 2'b00)) begin
        r_win[w_t_lo] <= w_sum;
      end
    end
  end

`ifdef W_SCHED_BLKCNT_EN
  logic [15:0] r_blk_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_blk_count <= 16'd0;
    end else if (w_drain_done) begin
      r_blk_count <= r_blk_count + 16'd1;
    end
  end

  assign blk_count = r_blk_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_w_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_w_sched
// Purpose  : Directed self-checking bench for w_sched (schedule words, flow
//            control, reset abort, optional block counter).
// Revision : 1.0  initial release
// ============================================================================
module tb_w_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        blk_valid = 1'b0;
  logic [31:0] blk_word = 32'd0;
  logic        w_ready = 1'b0;
  logic        blk_ready;
  logic        w_valid;
  logic [31:0] w_out;
  logic [5:0]  w_idx;
  logic        w_last;
  logic        busy;
`ifdef W_SCHED_BLKCNT_EN
  logic [15:0] blk_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  always #5 clock = ~clock;

  w_sched dut (
    .clock     (clock),
    .reset     (reset),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_word  (blk_word),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_out     (w_out),
    .w_idx     (w_idx),
    .w_last    (w_last),
    .busy      (busy)
`ifdef W_SCHED_BLKCNT_EN
    ,
    .blk_count (blk_count)
`endif
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_exp();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = blk[t];
      else exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h6162_6380;
    blk[15] = 32'h0000_0018;
    build_exp();
  endtask

  task automatic set_fill(input logic [31:0] v);
    for (int i = 0; i < 16; i++) blk[i] = v;
    build_exp();
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 16; i++) blk[i] = (32'h0101_0101 * i) ^ 32'hA5A5_A5A5;
    build_exp();
  endtask

  // Returns #1 after the edge that accepted the last word.
  task automatic load_words(input int n);
    int g;
    bit tmo;
    tmo = 1'b0;
    for (int i = 0; i < n; i++) begin
      g = 0;
      @(negedge clock);
      blk_valid = 1'b1;
      blk_word  = blk[i];
      while (blk_ready !== 1'b1 && g < 300) begin
        @(negedge clock);
        g++;
      end
      if (g >= 300) tmo = 1'b1;
      @(posedge clock);
      #1;
    end
    blk_valid = 1'b0;
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL load_timeout: blk_ready never high, got=%b required=1", blk_ready);
    end
  endtask

  // Returns #1 after the edge carrying the n-th handshake.
  task automatic collect(input bit rnd, input int n, output int cycles);
    int          got;
    bit          stalled;
    bit          ctrl_bad;
    logic [31:0] pv;
    logic [5:0]  pi;
    logic        pl;
    got = 0; stalled = 1'b0; ctrl_bad = 1'b0; pv = '0; pi = '0; pl = 1'b0;
    cycles = 0;
    while (got < n && cycles < 4000) begin
      @(negedge clock);
      cycles++;
      if (stalled) begin
        checks++;
        if (w_valid !== 1'b1 || w_out !== pv || w_idx !== pi || w_last !== pl) begin
          errors++;
          $display("FAIL stall_hold: got v=%b idx=%0d w=%h last=%b required v=1 idx=%0d w=%h last=%b",
                   w_valid, w_idx, w_out, w_last, pi, pv, pl);
        end
      end
      if (blk_ready !== 1'b0 || busy !== 1'b1) ctrl_bad = 1'b1;
      w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_valid === 1'b1 && w_ready) begin
        got_w[got] = w_out;
        checks++;
        if (w_idx !== 6'(got) || w_out !== exp_w[got]) begin
          errors++;
          $display("FAIL word: got idx=%0d w=%h required idx=%0d w=%h", w_idx, w_out, got, exp_w[got]);
        end
        checks++;
        if (w_last !== (got == 63)) begin
          errors++;
          $display("FAIL last: idx=%0d got=%b required=%b", got, w_last, (got == 63));
        end
        got++;
      end
      stalled = (w_valid === 1'b1) && !w_ready;
      pv = w_out; pi = w_idx; pl = w_last;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL handshake_count: got=%0d required=%0d", got, n);
    end
    checks++;
    if (ctrl_bad) begin
      errors++;
      $display("FAIL run_ctrl: blk_ready/busy wrong during RUN, got ready=%b busy=%b required 0/1", blk_ready, busy);
    end
    @(posedge clock);
    #1;
    w_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clock);
    checks++;
    if (blk_ready !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got ready=%b valid=%b busy=%b required 1/0/0", tag, blk_ready, w_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    blk_valid = 1'b1;
    blk_word  = 32'h1234_5678;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({blk_ready, w_valid, busy, w_last} !== 4'b0000 || w_out !== 32'd0 || w_idx !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: got r=%b v=%b b=%b l=%b w=%h i=%0d required all zero",
               blk_ready, w_valid, busy, w_last, w_out, w_idx);
    end
    reset     = 1'b1;
    blk_valid = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (blk_ready !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b valid=%b required 1/0/0", blk_ready, busy, w_valid);
    end
  endtask

  task automatic test_abc();
    int cyc;
    set_abc();
    load_words(16);
    @(negedge clock);
    checks++;
    if (w_valid !== 1'b0 || busy !== 1'b1 || blk_ready !== 1'b0) begin
      errors++;
      $display("FAIL abc_latency: got valid=%b busy=%b ready=%b required 0/1/0", w_valid, busy, blk_ready);
    end
    collect(1'b0, 64, cyc);
    checks++;
    if (cyc != 64) begin
      errors++;
      $display("FAIL abc_rate: got cycles=%0d required=64", cyc);
    end
    checks++;
    if (got_w[0] !== 32'h6162_6380 || got_w[16] !== 32'h6162_6380 || got_w[17] !== 32'h000F_0000) begin
      errors++;
      $display("FAIL abc_known: got W0=%h W16=%h W17=%h required 61626380/61626380/000f0000",
               got_w[0], got_w[16], got_w[17]);
    end
    check_idle("abc_done");
  endtask

  task automatic test_const();
    int cyc;
    set_fill(32'h384b_5d26);
    load_words(16);
    collect(1'b0, 64, cyc);
    checks++;
    if (got_w[0] !== 32'h384b_5d26 || got_w[15] !== 32'h384b_5d26) begin
      errors++;
      $display("FAIL const_echo: got W0=%h W15=%h required 384b5d26", got_w[0], got_w[15]);
    end
    check_idle("const_done");
  endtask

  task automatic test_backpressure();
    int cyc;
    set_abc();
    load_words(16);
    collect(1'b1, 64, cyc);
    check_idle("bp_done");
  endtask

  task automatic test_back_to_back();
    int cyc;
    set_fill(32'h0F1E_2D3C);
    load_words(16);
    blk_valid = 1'b1;
    blk_word  = 32'hDEAD_BEEF;
    collect(1'b0, 64, cyc);
    blk_valid = 1'b0;
    check_idle("ignore_done");
    set_ramp();
    load_words(16);
    collect(1'b0, 64, cyc);
    check_idle("second_done");
  endtask

  task automatic test_reset_mid();
    int cyc;
    set_fill(32'hCAFE_F00D);
    load_words(8);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    set_abc();
    load_words(16);
    collect(1'b0, 64, cyc);
    check_idle("abort_load_done");
    set_ramp();
    load_words(16);
    collect(1'b0, 30, cyc);
    @(negedge clock);
    checks++;
    if (w_valid !== 1'b1 || w_idx !== 6'd30) begin
      errors++;
      $display("FAIL mid_run_pos: got valid=%b idx=%0d required 1/30", w_valid, w_idx);
    end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (w_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset: got valid=%b busy=%b required 0/0", w_valid, busy);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (blk_ready !== 1'b1 || w_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_release: got ready=%b valid=%b required 1/0", blk_ready, w_valid);
    end
    set_fill(32'h384b_5d26);
    load_words(16);
    collect(1'b0, 64, cyc);
    check_idle("after_abort_done");
  endtask

`ifdef W_SCHED_BLKCNT_EN
  task automatic test_blk_count();
    int cyc;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    checks++;
    if (blk_count !== 16'd0) begin
      errors++;
      $display("FAIL blkcnt_reset: got=%0d required=0", blk_count);
    end
    for (int b = 0; b < 3; b++) begin
      set_ramp();
      load_words(16);
      collect(1'b0, 64, cyc);
    end
    checks++;
    if (blk_count !== 16'd3) begin
      errors++;
      $display("FAIL blkcnt_three: got=%0d required=3", blk_count);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    void'($urandom(32'd12345));
    test_reset();
    test_abc();
    test_const();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef W_SCHED_BLKCNT_EN
    test_blk_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
